// File: rtl/fpnew_pkg.sv
// fpnew_pkg (codebase slice)
//
// Shared FPU types used by the result reorder buffer.
// Only the IEEE exception flag record is needed here.
// The field order matches the fflags CSR layout, from MSB to LSB:
// invalid, divide-by-zero, overflow, underflow, inexact.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_rob_slot.sv
// fpnew_rob_slot
//
// A single entry of the in-order completion buffer.
// It holds the allocation and completion flags together with the result
// payload and the issue tag.
//
// Ports:
//   clk_i, rst_i      clock and asynchronous active-high reset
//   flush_i           kills the entry; overrides every other control
//   retire_i          entry leaves the head; clears alloc and done
//   alloc_i, tag_i    issue allocation; stores the tag and clears done
//   write_i           completion write of result/status/ext; sets done
//   result_i, status_i, ext_bit_i   completion payload
//   alloc_o, done_o, result_o, status_o, ext_bit_o, tag_o   entry contents
module fpnew_rob_slot
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter type         TagType = logic
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic             alloc_i,
    input  TagType           tag_i,
    input  logic             write_i,
    input  logic [Width-1:0] result_i,
    input  status_t          status_i,
    input  logic             ext_bit_i,
    output logic             alloc_o,
    output logic             done_o,
    output logic [Width-1:0] result_o,
    output status_t          status_o,
    output logic             ext_bit_o,
    output TagType           tag_o
);

    logic             alloc_q;
    logic             done_q;
    logic [Width-1:0] result_q;
    status_t          status_q;
    logic             extBit_q;
    TagType           tag_q;

    // Retire, allocate and write never target the same entry in one cycle
    // while the parent honours the protocol. The ordering below only
    // decides what happens if they do collide.
    // Payload registers keep their old contents when the entry is freed.
    // This is harmless because done gates the entry's visibility.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            extBit_q <= 1'b0;
            tag_q    <= '0;
        end else if (flush_i) begin
            alloc_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (retire_i) begin
            alloc_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (alloc_i) begin
            alloc_q <= 1'b1;
            done_q  <= 1'b0;
            tag_q   <= tag_i;
        end else if (write_i) begin
            done_q   <= 1'b1;
            result_q <= result_i;
            status_q <= status_i;
            extBit_q <= ext_bit_i;
        end
    end

    assign alloc_o   = alloc_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign status_o  = status_q;
    assign ext_bit_o = extBit_q;
    assign tag_o     = tag_q;

endmodule

// File: rtl/fpnew_result_reorder.sv
// fpnew_result_reorder
//
// This is an in-order completion buffer that sits behind the opgroup blocks.
// The issue stage allocates a slot and receives its ID on issue_id_o.
// Results come back out of order on the per-source completion ports and are
// written into the slot they address. The head slot is presented on a single
// valid/ready output, so results leave strictly in issue order.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   flush_i                      synchronous kill of every slot
//   issue_valid_i/ready_o        allocation handshake
//   issue_tag_i, issue_id_o      tag to store, ID of the next slot allocated
//   cpl_valid_i/ready_o          per-source completion handshake (always ready)
//   cpl_id_i, cpl_result_i, cpl_status_i, cpl_ext_bit_i   completion payload
//   out_valid_o/out_ready_i      head slot handshake
//   result_o, status_o, extension_bit_o, tag_o            head slot contents
//   busy_o                       at least one slot is allocated
module fpnew_result_reorder
    import fpnew_pkg::*;
#(
    parameter int unsigned  NumSources = 4,
    parameter int unsigned  Depth      = 8,
    parameter int unsigned  Width      = 32,
    parameter type          TagType    = logic,
    localparam int unsigned IdWidth    = $clog2(Depth),
    localparam int unsigned CntWidth   = IdWidth + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                issue_valid_i,
    output logic                                issue_ready_o,
    input  TagType                              issue_tag_i,
    output logic [IdWidth-1:0]                  issue_id_o,
    input  logic [NumSources-1:0]               cpl_valid_i,
    output logic [NumSources-1:0]               cpl_ready_o,
    input  logic [NumSources-1:0][IdWidth-1:0]  cpl_id_i,
    input  logic [NumSources-1:0][Width-1:0]    cpl_result_i,
    input  status_t [NumSources-1:0]            cpl_status_i,
    input  logic [NumSources-1:0]               cpl_ext_bit_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [Width-1:0]                    result_o,
    output status_t                             status_o,
    output logic                                extension_bit_o,
    output TagType                              tag_o,
    output logic                                busy_o
);

    logic [CntWidth-1:0] wrPtr_q, wrPtr_d;
    logic [CntWidth-1:0] rdPtr_q, rdPtr_d;
    logic [IdWidth-1:0]  wrIdx, rdIdx;
    logic                isEmpty, isFull;
    logic                issueFire, retireFire;

    logic [Depth-1:0]             slotAlloc, slotDone, slotExt;
    logic [Depth-1:0][Width-1:0]  slotResult;
    status_t [Depth-1:0]          slotStatus;
    TagType                       slotTag [Depth];

    logic [Depth-1:0]             writeEn, writeExt;
    logic [Depth-1:0][Width-1:0]  writeResult;
    status_t [Depth-1:0]          writeStatus;

    assign wrIdx = wrPtr_q[IdWidth-1:0];
    assign rdIdx = rdPtr_q[IdWidth-1:0];

    // The MSB of each pointer is a wrap bit.
    // Matching slot indices mean empty when the wrap bits agree and full
    // when they differ.
    assign isEmpty = (wrPtr_q == rdPtr_q);
    assign isFull  = (wrIdx == rdIdx) && (wrPtr_q[IdWidth] != rdPtr_q[IdWidth]);

    // issue_ready_o deliberately ignores a same-cycle retire. This keeps the
    // issue path free of any dependency on the consumer's ready.
    assign issue_ready_o = !isFull && !flush_i;
    assign issueFire     = issue_valid_i && issue_ready_o;
    assign issue_id_o    = wrIdx;

    assign out_valid_o = !flush_i && !isEmpty && slotAlloc[rdIdx] && slotDone[rdIdx];
    assign retireFire  = out_valid_o && out_ready_i;

    assign cpl_ready_o = '1;
    assign busy_o      = !isEmpty;

    assign result_o        = slotResult[rdIdx];
    assign status_o        = slotStatus[rdIdx];
    assign extension_bit_o = slotExt[rdIdx];
    assign tag_o           = slotTag[rdIdx];

    // Completion write-select. Each slot accepts only a write aimed at it
    // while it is allocated and not yet done. Sources are scanned from the
    // highest index down, so the lowest-indexed source wins a collision.
    always_comb begin
        writeEn     = '0;
        writeExt    = '0;
        writeResult = '0;
        writeStatus = '0;
        for (int d = 0; d < int'(Depth); d++) begin
            for (int s = int'(NumSources) - 1; s >= 0; s--) begin
                if (cpl_valid_i[s] && (cpl_id_i[s] == IdWidth'(d)) &&
                    slotAlloc[d] && !slotDone[d]) begin
                    writeEn[d]     = 1'b1;
                    writeResult[d] = cpl_result_i[s];
                    writeStatus[d] = cpl_status_i[s];
                    writeExt[d]    = cpl_ext_bit_i[s];
                end
            end
        end
    end

    // Pointer next-state logic. A flush returns both pointers to slot 0.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (issueFire) begin
                wrPtr_d = wrPtr_q + CntWidth'(1);
            end
            if (retireFire) begin
                rdPtr_d = rdPtr_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    for (genvar d = 0; d < Depth; d++) begin : gen_slots
        fpnew_rob_slot #(
            .Width   (Width),
            .TagType (TagType)
        ) i_slot (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flush_i   (flush_i),
            .retire_i  (retireFire && (rdIdx == IdWidth'(d))),
            .alloc_i   (issueFire && (wrIdx == IdWidth'(d))),
            .tag_i     (issue_tag_i),
            .write_i   (writeEn[d]),
            .result_i  (writeResult[d]),
            .status_i  (writeStatus[d]),
            .ext_bit_i (writeExt[d]),
            .alloc_o   (slotAlloc[d]),
            .done_o    (slotDone[d]),
            .result_o  (slotResult[d]),
            .status_o  (slotStatus[d]),
            .ext_bit_o (slotExt[d]),
            .tag_o     (slotTag[d])
        );
    end

    // Protocol checks.
    assert property (@(posedge clk_i) ((Depth >= 2) && ((Depth & (Depth - 1)) == 0)));

    for (genvar s = 0; s < NumSources; s++) begin : gen_cpl_checks
        assert property (@(posedge clk_i) disable iff (rst_i)
            cpl_valid_i[s] |-> (flush_i || (slotAlloc[cpl_id_i[s]] && !slotDone[cpl_id_i[s]])));
        for (genvar t = s + 1; t < NumSources; t++) begin : gen_dup
            assert property (@(posedge clk_i) disable iff (rst_i)
                !(cpl_valid_i[s] && cpl_valid_i[t] && (cpl_id_i[s] == cpl_id_i[t])));
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=>
            (flush_i || (out_valid_o && $stable(result_o) && $stable(status_o) &&
                         $stable(extension_bit_o) && $stable(tag_o))));

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// tb_fpnew_result_reorder
//
// Directed bench for the in-order completion buffer. It covers reset
// values, basic out-of-order completion, full and wrap behaviour,
// simultaneous completions, backpressure, flush and an asynchronous
// reset taken mid-operation.
module tb_fpnew_result_reorder;
    import fpnew_pkg::*;

    localparam int NumSources = 4;
    localparam int Depth      = 8;
    localparam int Width      = 32;
    localparam int IdWidth    = 3;

    typedef logic [7:0] tag_t;

    logic                               clock = 1'b0;
    logic                               reset;
    logic                               flush;
    logic                               issueValid;
    logic                               issueReady;
    tag_t                               issueTag;
    logic [IdWidth-1:0]                 issueId;
    logic [NumSources-1:0]              cplValid;
    logic [NumSources-1:0]              cplReady;
    logic [NumSources-1:0][IdWidth-1:0] cplId;
    logic [NumSources-1:0][Width-1:0]   cplResult;
    status_t [NumSources-1:0]           cplStatus;
    logic [NumSources-1:0]              cplExt;
    logic                               outValid;
    logic                               outReady;
    logic [Width-1:0]                   result;
    status_t                            status;
    logic                               extBit;
    tag_t                               tag;
    logic                               busy;

    int checkCount = 0;
    int failCount  = 0;

    // The clock has a 10-unit period. Inputs change 1 unit after each
    // rising edge, and outputs are compared at least 1 unit after that.
    always #5 clock = ~clock;

    fpnew_result_reorder #(
        .NumSources (NumSources),
        .Depth      (Depth),
        .Width      (Width),
        .TagType    (tag_t)
    ) dut (
        .clk_i           (clock),
        .rst_i           (reset),
        .flush_i         (flush),
        .issue_valid_i   (issueValid),
        .issue_ready_o   (issueReady),
        .issue_tag_i     (issueTag),
        .issue_id_o      (issueId),
        .cpl_valid_i     (cplValid),
        .cpl_ready_o     (cplReady),
        .cpl_id_i        (cplId),
        .cpl_result_i    (cplResult),
        .cpl_status_i    (cplStatus),
        .cpl_ext_bit_i   (cplExt),
        .out_valid_o     (outValid),
        .out_ready_i     (outReady),
        .result_o        (result),
        .status_o        (status),
        .extension_bit_o (extBit),
        .tag_o           (tag),
        .busy_o          (busy)
    );

    // Every comparison goes through this task. It counts the check and
    // reports any difference between the observed and expected values.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives the scalar controls and lets the combinational outputs settle.
    task automatic applyStimulus(input logic issueV, input tag_t issueT,
                                 input logic outR, input logic flushV);
        issueValid = issueV;
        issueTag   = issueT;
        outReady   = outR;
        flush      = flushV;
        #1;
    endtask

    // Drives a completion on one source.
    // It takes effect at the next rising edge.
    task automatic applyCompletion(input int src, input logic [IdWidth-1:0] id,
                                   input logic [Width-1:0] res, input status_t st,
                                   input logic ext);
        cplValid[src]  = 1'b1;
        cplId[src]     = id;
        cplResult[src] = res;
        cplStatus[src] = st;
        cplExt[src]    = ext;
    endtask

    task automatic clearCompletions();
        cplValid  = '0;
        cplId     = '0;
        cplResult = '0;
        cplStatus = '0;
        cplExt    = '0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Checks every output against its reset value.
    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_issue_ready"}, issueReady, 1);
        checkOutput({phase, "_out_valid"},   outValid,   0);
        checkOutput({phase, "_busy"},        busy,       0);
        checkOutput({phase, "_issue_id"},    issueId,    0);
        checkOutput({phase, "_result"},      result,     0);
        checkOutput({phase, "_status"},      status,     0);
        checkOutput({phase, "_ext"},         extBit,     0);
        checkOutput({phase, "_tag"},         tag,        0);
        checkOutput({phase, "_cpl_ready"},   cplReady,   4'hF);
    endtask

    initial begin
        status_t stNx, stNv, stNone;
        stNx   = 5'b00001;
        stNv   = 5'b10000;
        stNone = 5'b00000;

        clearCompletions();
        issueValid = 1'b0;
        issueTag   = '0;
        outReady   = 1'b0;
        flush      = 1'b0;
        reset      = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkResetValues("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;

        $display("[TB] basic out-of-order completion");
        applyStimulus(1, 8'h0A, 0, 0);
        checkOutput("basic_id0", issueId, 0);
        nextCycle();
        applyStimulus(1, 8'h0B, 0, 0);
        checkOutput("basic_id1", issueId, 1);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("basic_busy", busy, 1);
        checkOutput("basic_id2", issueId, 2);
        applyCompletion(2, 3'd1, 32'h0000_0111, stNv, 1'b1);
        #1;
        checkOutput("basic_no_bypass1", outValid, 0);
        nextCycle();
        clearCompletions();
        checkOutput("basic_head_not_done", outValid, 0);
        applyCompletion(0, 3'd0, 32'h0000_0100, stNx, 1'b0);
        #1;
        checkOutput("basic_no_bypass0", outValid, 0);
        nextCycle();
        clearCompletions();
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("basic_valid_a",  outValid, 1);
        checkOutput("basic_tag_a",    tag,      8'h0A);
        checkOutput("basic_result_a", result,   32'h100);
        checkOutput("basic_status_a", status,   5'h01);
        checkOutput("basic_ext_a",    extBit,   0);
        nextCycle();
        checkOutput("basic_valid_b",  outValid, 1);
        checkOutput("basic_tag_b",    tag,      8'h0B);
        checkOutput("basic_result_b", result,   32'h111);
        checkOutput("basic_status_b", status,   5'h10);
        checkOutput("basic_ext_b",    extBit,   1);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("basic_drained_valid", outValid, 0);
        checkOutput("basic_drained_busy",  busy,     0);

        // A flush on an empty buffer returns both pointers to slot 0.
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("flush_idle_ready", issueReady, 0);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("flush_idle_id", issueId, 0);

        $display("[TB] fill to full and wrap");
        for (int i = 0; i < Depth; i++) begin
            applyStimulus(1, tag_t'(8'h10 + i), 0, 0);
            checkOutput("full_issue_id", issueId, i);
            checkOutput("full_issue_ready", issueReady, 1);
            nextCycle();
        end
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("full_ready", issueReady, 0);
        checkOutput("full_busy",  busy,       1);
        checkOutput("full_id",    issueId,    0);
        applyCompletion(1, 3'd0, 32'h0000_00F0, stNone, 1'b0);
        nextCycle();
        clearCompletions();
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("full_head_valid", outValid, 1);
        checkOutput("full_head_tag",   tag,      8'h10);
        checkOutput("full_ready_during_retire", issueReady, 0);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("full_ready_after_retire", issueReady, 1);
        checkOutput("full_wrapped_id", issueId, 0);
        checkOutput("full_next_not_done", outValid, 0);
        applyStimulus(1, 8'h55, 0, 0);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("refull_ready", issueReady, 0);

        $display("[TB] simultaneous completions");
        applyCompletion(0, 3'd4, 32'h0000_0404, stNone, 1'b0);
        applyCompletion(1, 3'd3, 32'h0000_0403, stNone, 1'b0);
        applyCompletion(2, 3'd2, 32'h0000_0402, stNone, 1'b0);
        applyCompletion(3, 3'd1, 32'h0000_0401, stNone, 1'b0);
        nextCycle();
        clearCompletions();
        applyStimulus(0, 8'h00, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("simul_valid",  outValid, 1);
            checkOutput("simul_tag",    tag,      tag_t'(8'h10 + i));
            checkOutput("simul_result", result,   32'h400 + i);
            nextCycle();
        end
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("simul_end_valid", outValid, 0);
        checkOutput("simul_ready",     issueReady, 1);

        $display("[TB] backpressure");
        applyCompletion(3, 3'd5, 32'h0000_BEEF, stNone, 1'b0);
        nextCycle();
        clearCompletions();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid",  outValid, 1);
            checkOutput("bp_result", result,   32'hBEEF);
            checkOutput("bp_tag",    tag,      8'h15);
            nextCycle();
        end
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("bp_valid_on_ready", outValid, 1);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("bp_retired", outValid, 0);
        checkOutput("bp_issue_id", issueId, 1);

        $display("[TB] flush");
        // Slots 6, 7 and 0 are allocated. Completing slot 7 leaves one done.
        applyCompletion(2, 3'd7, 32'h0000_7777, stNone, 1'b0);
        nextCycle();
        clearCompletions();
        applyStimulus(1, 8'h77, 0, 1);
        checkOutput("flush_ready_forced", issueReady, 0);
        checkOutput("flush_valid_forced", outValid,   0);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("flush_busy",  busy,       0);
        checkOutput("flush_id",    issueId,    0);
        checkOutput("flush_valid", outValid,   0);
        checkOutput("flush_ready", issueReady, 1);

        $display("[TB] asynchronous reset mid-operation");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, tag_t'(8'h30 + i), 0, 0);
            nextCycle();
        end
        applyStimulus(0, 8'h00, 0, 0);
        applyCompletion(0, 3'd0, 32'h0000_CAFE, stNx, 1'b1);
        nextCycle();
        clearCompletions();
        #1;
        checkOutput("pre_reset_valid",  outValid, 1);
        checkOutput("pre_reset_result", result,   32'hCAFE);
        checkOutput("pre_reset_busy",   busy,     1);
        #2 reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        nextCycle();
        reset = 1'b0;
        #1;
        applyStimulus(1, 8'h42, 0, 0);
        checkOutput("post_reset_id", issueId, 0);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        applyCompletion(1, 3'd0, 32'h0000_0042, stNone, 1'b0);
        nextCycle();
        clearCompletions();
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("post_reset_valid", outValid, 1);
        checkOutput("post_reset_tag",   tag,      8'h42);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("post_reset_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
